arbitro_rr: RTL and testbench
=============================

ARBITRO_RR -- requirements
Module: arbitro_rr

Interface
REQ-001 Parameter N_PORTS, default 4: input/output FIFO pair count; power of 2, range 2..8.
REQ-002 Parameter DATA_WIDTH, default 10: FIFO word width.
REQ-003 Parameter DEST_W, default 2: destination field width, equal to log2(N_PORTS), located at word bits [DATA_WIDTH-1:DATA_WIDTH-DEST_W].
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  arbitration enable.
REQ-007 empty  input  N_PORTS  empty flags of input FIFOs, bit i = FIFO i.
REQ-008 almostfull  input  N_PORTS  almost-full flags of output FIFOs, bit j = FIFO j.
REQ-009 data_in  input  N_PORTS*DATA_WIDTH  head words of input FIFOs (show-ahead), word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 pop  output  N_PORTS  read enables to input FIFOs, combinational.
REQ-011 push  output  N_PORTS  write enables to output FIFOs, registered.
REQ-012 data_out  output  DATA_WIDTH  word broadcast to all output FIFOs, registered; qualified by push.
REQ-013 idle  output  1  high when FSM is IDLE and no push is pending.

Function
REQ-014 FSM states: IDLE and ACTIVE; IDLE -> ACTIVE when enable=1; ACTIVE -> IDLE when enable=0.
REQ-015 In IDLE, pop shall be all zero.
REQ-016 In ACTIVE, input i is eligible iff empty[i]=0 and almostfull[dest(data_in word i)]=0.
REQ-017 At most one pop bit is high per cycle; it is the granted eligible input; no eligible input -> pop=0.
REQ-018 Grant order: search from round-robin pointer ptr upward with wrap modulo N_PORTS; first eligible wins.
REQ-019 On a grant to input g, ptr <= (g+1) mod N_PORTS; without a grant, ptr is held.
REQ-020 The cycle after a grant, data_out <= granted word and push[dest] = 1 for exactly one cycle; latency pop-to-push is 1 clock.
REQ-021 Without a grant in the previous cycle, push = 0 and data_out holds its last value.
REQ-022 A grant made in the cycle enable falls still produces its push in the following cycle.
REQ-023 Back-to-back grants on consecutive cycles are allowed; throughput 1 word/clock.
REQ-024 Output FIFO almost-full thresholds leave at least 1 free slot for the in-flight word; the block does not re-check almostfull at push time.
REQ-025 Multiple inputs may target the same destination; per-destination blocking does not stall inputs with other destinations.

Reset
REQ-026 While reset=1: pop=0, push=0, data_out=0, FSM=IDLE, ptr=0, idle=1, independent of clk.
REQ-027 Reset asserted mid-transfer discards the pending push; no push occurs on the first edge after deassertion.

Configuration
REQ-028 With macro ARBITRO_RR_EN defined: round-robin grant per REQ-018/019.
REQ-029 Without ARBITRO_RR_EN: fixed priority, lowest eligible index wins; ptr remains 0; all other behaviour unchanged.

Verification (N_PORTS=4, DATA_WIDTH=10)
REQ-030 enable=1, empty=4'b0000, all dest=2'b01, almostfull=0, 8 cycles -> pops in order 0,1,2,3,0,1,2,3; push=4'b0010 each cycle one clock after its pop; data_out matches the popped words.
REQ-031 Inputs 0 and 1 non-empty, word0=10'h3AA (dest 3), word1=10'h055 (dest 0), almostfull=4'b1000 -> only pop[1]; next cycle push=4'b0001, data_out=10'h055.
REQ-032 Without ARBITRO_RR_EN, empty=4'b0000, dest=0, 4 cycles -> pop=4'b0001 every cycle.
REQ-033 Grant on input 2 then reset pulsed before the next edge -> push stays 0, data_out=0, idle=1; after release and enable=1, the first grant starts search at input 0.
REQ-034 enable dropped in the same cycle as a grant of 10'h1C7 (dest 1) -> next cycle push=4'b0010, data_out=10'h1C7, pop=0; the cycle after that idle=1.
REQ-035 All inputs empty in ACTIVE for 5 cycles -> pop=0, push=0, ptr unchanged, data_out holds its last value.

Source files
------------

// File: rtl/arbitro_rr.sv
// arbitro_rr: arbiter that moves words from N_PORTS show-ahead input FIFOs
// to N_PORTS output FIFOs, one word per clock. The destination of a word is
// held in its top DEST_W bits.
// Optional feature: define ARBITRO_RR_EN for round-robin grant order.
// Without it, the grant is fixed priority (lowest eligible index wins).
module arbitro_rr #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 10,
  parameter int DEST_W     = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [N_PORTS-1:0]              empty,
  input  logic [N_PORTS-1:0]              almostfull,
  input  logic [N_PORTS*DATA_WIDTH-1:0]   data_in,
  output logic [N_PORTS-1:0]              pop,
  output logic [N_PORTS-1:0]              push,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            idle
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [DEST_W-1:0]       ptr;
  logic [DATA_WIDTH-1:0]   word     [N_PORTS];
  logic [DEST_W-1:0]       dest     [N_PORTS];
  logic [N_PORTS-1:0]      eligible;
  logic [DEST_W-1:0]       cand;
  logic                    gnt_vld;
  logic [DEST_W-1:0]       gnt_idx;

  // Unpack head words, extract destinations and flag eligible inputs.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      word[i]     = data_in[i*DATA_WIDTH +: DATA_WIDTH];
      dest[i]     = word[i][DATA_WIDTH-1 -: DEST_W];
      eligible[i] = !empty[i] && !almostfull[dest[i]];
    end
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and grant search starting at ptr, wrapping modulo N_PORTS.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    gnt_vld   = 1'b0;
    gnt_idx   = ptr;
    cand      = ptr;
    pop       = '0;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!enable) state_nxt = ST_IDLE;
        // A grant is still made in the cycle enable falls; its push follows.
        for (int k = 0; k < N_PORTS; k++) begin
          cand = ptr + DEST_W'(k);
          if (!gnt_vld && eligible[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
          end
        end
        if (gnt_vld) pop[gnt_idx] = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef ARBITRO_RR_EN
  // Round-robin pointer: moves just past the granted input, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= gnt_idx + DEST_W'(1);
    end
  end
`else
  // Fixed priority: the search always starts at input 0.
  assign ptr = '0;
`endif

  // Registered write side: the granted word goes out one clock after its pop.
  // Output FIFOs keep a free slot for this in-flight word, so almostfull is
  // not re-checked here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push     <= '0;
      data_out <= '0;
    end else if (gnt_vld) begin
      push     <= N_PORTS'(1) << dest[gnt_idx];
      data_out <= word[gnt_idx];
    end else begin
      push     <= '0;
    end
  end

  assign idle = (state == ST_IDLE) && (push == '0);

endmodule

// File: tb/tb_arbitro_rr.sv
// Self-checking bench for arbitro_rr (N_PORTS=4, DATA_WIDTH=10), with a
// behavioural reference model plus directed scenarios and random traffic.
module tb_arbitro_rr;

  localparam int N      = 4;
  localparam int DW     = 10;
  localparam int DEST_W = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [N-1:0]    empty;
  logic [N-1:0]    almostfull;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    pop;
  logic [N-1:0]    push;
  logic [DW-1:0]   data_out;
  logic            idle;

  always #5 clk = ~clk;

  arbitro_rr #(.N_PORTS(N), .DATA_WIDTH(DW), .DEST_W(DEST_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .empty      (empty),
    .almostfull (almostfull),
    .data_in    (data_in),
    .pop        (pop),
    .push       (push),
    .data_out   (data_out),
    .idle       (idle)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: arbitration on/off, search start, registered outputs.
  bit            m_active;
  int            m_ptr;
  logic [N-1:0]  m_push;
  logic [DW-1:0] m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int i);
    return data_in[i*DW +: DW];
  endfunction

  function automatic int word_dest(input int i);
    logic [DW-1:0] w;
    w = word_of(i);
    return int'(w) >> (DW - DEST_W);
  endfunction

  // Index of the input the arbiter should grant now, -1 if none.
  function automatic int model_grant();
    if (!m_active) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (!empty[i] && !almostfull[word_dest(i)]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_ptr    = 0;
    m_push   = '0;
    m_data   = '0;
  endtask

  task automatic model_edge();
    int g;
    if (reset) begin
      model_reset();
    end else begin
      g = model_grant();
      if (g >= 0) begin
        m_push = N'(1 << word_dest(g));
        m_data = word_of(g);
`ifdef ARBITRO_RR_EN
        m_ptr  = (g + 1) % N;
`endif
      end else begin
        m_push = '0;
      end
      m_active = enable;
    end
  endtask

  task automatic check_all(input string tag);
    int g;
    g = model_grant();
    check({tag, "_pop"},  32'(pop),      (g >= 0) ? 32'(1 << g) : 32'd0);
    check({tag, "_push"}, 32'(push),     32'(m_push));
    check({tag, "_data"}, 32'(data_out), 32'(m_data));
    check({tag, "_idle"}, 32'(idle),     32'(!m_active && (m_push == '0)));
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] w);
    data_in[i*DW +: DW] = w;
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    empty      = '1;
    almostfull = '0;
    data_in    = '0;
    model_reset();

    // Reset values, before any clock edge.
    #2;
    check("rst_pop",  32'(pop),      32'd0);
    check("rst_push", 32'(push),     32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_idle", 32'(idle),     32'd1);
    step("rst");
    reset = 1'b0;

`ifdef ARBITRO_RR_EN
    // All inputs full, all to destination 1: strict rotation 0,1,2,3,0,...
    for (int i = 0; i < N; i++) set_word(i, {2'b01, 8'(i * 17 + 3)});
    empty  = '0;
    enable = 1'b1;
    step("r030_en");
    for (int c = 0; c < 8; c++) begin
      check("r030_pop", 32'(pop), 32'(1 << (c % N)));
      if (c > 0) begin
        check("r030_push", 32'(push), 32'h2);
        check("r030_data", 32'(data_out), 32'(word_of((c - 1) % N)));
      end
      step("r030");
    end
    check("r030_push_last", 32'(push), 32'h2);
    check("r030_data_last", 32'(data_out), 32'(word_of(N - 1)));
`else
    // Fixed priority: input 0 wins every cycle.
    for (int i = 0; i < N; i++) set_word(i, {2'b00, 8'(i * 29 + 5)});
    empty  = '0;
    enable = 1'b1;
    step("r032_en");
    for (int c = 0; c < 4; c++) begin
      check("r032_pop", 32'(pop), 32'h1);
      step("r032");
    end
`endif

    // Reset pulse so the next scenario starts from ptr 0.
    reset = 1'b1;
    model_reset();
    step("rst2");
    reset = 1'b0;

    // Blocked destination skips input 0 but still serves input 1.
    empty  = '1;
    enable = 1'b1;
    step("r031_en");
    empty      = 4'b1100;
    set_word(0, 10'h3AA);
    set_word(1, 10'h055);
    almostfull = 4'b1000;
    #1;
    check("r031_pop", 32'(pop), 32'h2);
    step("r031");
    empty      = '1;
    almostfull = '0;
    check("r031_push", 32'(push), 32'h1);
    check("r031_data", 32'(data_out), 32'h055);
    step("r031_b");

    // Grant on input 2, then reset before the next edge discards its push.
    empty = 4'b1011;
    set_word(2, 10'h08C);
    #1;
    check("r033_pop", 32'(pop), 32'h4);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("r033_pop_rst",  32'(pop),      32'd0);
    check("r033_push_rst", 32'(push),     32'd0);
    check("r033_data_rst", 32'(data_out), 32'd0);
    check("r033_idle_rst", 32'(idle),     32'd1);
    step("r033_rst");
    check("r033_push_hold", 32'(push), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_word(i, 10'(i * 7 + 1));
    empty  = '0;
    enable = 1'b1;
    step("r033_rel");
    check("r033_push_rel", 32'(push), 32'd0);
    check("r033_pop_first", 32'(pop), 32'h1);
    step("r033_g");

    // enable drops in the same cycle as a grant; the push still follows.
    empty = 4'b1110;
    set_word(0, 10'h1C7);
    enable = 1'b0;
    #1;
    check("r034_pop", 32'(pop), 32'h1);
    step("r034");
    check("r034_push", 32'(push),     32'h2);
    check("r034_data", 32'(data_out), 32'h1C7);
    check("r034_pop0", 32'(pop),      32'd0);
    check("r034_busy", 32'(idle),     32'd0);
    step("r034_b");
    check("r034_idle", 32'(idle), 32'd1);

    // Active but all inputs empty: nothing moves, data_out holds.
    enable = 1'b1;
    empty  = '1;
    step("r035_en");
    for (int c = 0; c < 5; c++) begin
      check("r035_pop",  32'(pop),      32'd0);
      check("r035_push", 32'(push),     32'd0);
      check("r035_data", 32'(data_out), 32'h1C7);
      step("r035");
    end
    // Pointer was held: the search resumes just past the last grant (input 0).
    empty = '0;
    #1;
`ifdef ARBITRO_RR_EN
    check("r035_ptr", 32'(pop), 32'h2);
`else
    check("r035_ptr", 32'(pop), 32'h1);
`endif
    step("r035_ptr");

    // Random traffic against the model, with occasional resets.
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      if (reset) model_reset();
      enable     = ($urandom_range(0, 7) != 0);
      empty      = N'($urandom);
      almostfull = N'($urandom);
      for (int i = 0; i < N; i++) set_word(i, DW'($urandom));
      step("rnd");
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
